// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX stage: forwarding select encodings,
// the return-address register number and the E-stage control bundle.
package pipe_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_LOAD = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
    logic aluimm;
    logic shift;
    logic jal;
  } e_ctrl_t;

endpackage

// File: rtl/idex_fwd_stage_if.sv
// Bundle of ID-side inputs, M-stage hazard inputs and E-stage / forwarding
// outputs of the ID/EX stage. master = surrounding pipeline, slave = the stage.
interface idex_fwd_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int AW = 4
);
  logic [RW-1:0] rs, rt, rd;
  logic          use_rs, use_rt;
  logic [DW-1:0] da, db, dimm, dpc4;
  logic          dwreg, dm2reg, dwmem, daluimm, dshift, djal, dregrt;
  logic [AW-1:0] daluc;
  logic          flush;
  logic          mwreg, mm2reg;
  logic [RW-1:0] mrn;

  logic [1:0]    fwda, fwdb;
  logic          wpcir;
  logic [DW-1:0] ea, eb, eimm, epc4;
  logic          ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
  logic [AW-1:0] ealuc;
  logic [RW-1:0] ern;

  modport master (
    output rs, rt, rd, use_rs, use_rt, da, db, dimm, dpc4,
           dwreg, dm2reg, dwmem, daluimm, dshift, djal, dregrt, daluc,
           flush, mwreg, mm2reg, mrn,
    input  fwda, fwdb, wpcir, ea, eb, eimm, epc4,
           ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ern
  );

  modport slave (
    input  rs, rt, rd, use_rs, use_rt, da, db, dimm, dpc4,
           dwreg, dm2reg, dwmem, daluimm, dshift, djal, dregrt, daluc,
           flush, mwreg, mm2reg, mrn,
    output fwda, fwdb, wpcir, ea, eb, eimm, epc4,
           ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ern
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forwarding select and load-use stall detection,
// comparing ID source registers against the E and M stage destinations.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] i_rs,
  input  logic [RW-1:0] i_rt,
  input  logic          i_use_rs,
  input  logic          i_use_rt,
  input  logic          i_ewreg,
  input  logic          i_em2reg,
  input  logic [RW-1:0] i_ern,
  input  logic          i_mwreg,
  input  logic          i_mm2reg,
  input  logic [RW-1:0] i_mrn,
  output logic [1:0]    o_fwda,
  output logic [1:0]    o_fwdb,
  output logic          o_stall
);

  logic w_e_load_rs;
  logic w_e_load_rt;

  // E is checked first so the newest producer wins; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (i_ewreg && !i_em2reg && (i_ern != '0) && (i_ern == src))
      return FWD_EXE;
    else if (i_mwreg && !i_mm2reg && (i_mrn != '0) && (i_mrn == src))
      return FWD_MEM;
    else if (i_mwreg && i_mm2reg && (i_mrn != '0) && (i_mrn == src))
      return FWD_LOAD;
    else
      return FWD_REG;
  endfunction

  assign o_fwda = fwd_sel(i_rs);
  assign o_fwdb = fwd_sel(i_rt);

  // A load in E cannot forward yet; any dependent reader must wait one cycle.
  assign w_e_load_rs = i_use_rs && (i_ern == i_rs);
  assign w_e_load_rt = i_use_rt && (i_ern == i_rt);
  assign o_stall     = i_ewreg && i_em2reg && (i_ern != '0) &&
                       (w_e_load_rs || w_e_load_rt);

endmodule

// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with operand forwarding and load-use interlock;
// stalls and flushes turn the next E-stage slot into a bubble.
module idex_fwd_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int AW = 4
) (
  input logic            clk,
  input logic            rst,
  idex_fwd_stage_if.slave bus
);

  logic [RW-1:0] w_drn;
  logic          w_stall;
  e_ctrl_t       w_dctrl;

  e_ctrl_t       r_ectrl;
  logic [DW-1:0] r_ea, r_eb, r_eimm, r_epc4;
  logic [AW-1:0] r_ealuc;
  logic [RW-1:0] r_ern;

  hazard_fwd_unit #(.RW(RW)) u_hazard (
    .i_rs     (bus.rs),
    .i_rt     (bus.rt),
    .i_use_rs (bus.use_rs),
    .i_use_rt (bus.use_rt),
    .i_ewreg  (r_ectrl.wreg),
    .i_em2reg (r_ectrl.m2reg),
    .i_ern    (r_ern),
    .i_mwreg  (bus.mwreg),
    .i_mm2reg (bus.mm2reg),
    .i_mrn    (bus.mrn),
    .o_fwda   (bus.fwda),
    .o_fwdb   (bus.fwdb),
    .o_stall  (w_stall)
  );

  // NOTE: assign a default first so every path drives w_drn and no latch is inferred.
  always_comb begin
    w_drn = bus.rd;
    if (bus.dregrt) w_drn = bus.rt;
    if (bus.djal)   w_drn = RW'(REG_RA);
  end

  assign w_dctrl = '{wreg:   bus.dwreg,
                     m2reg:  bus.dm2reg,
                     wmem:   bus.dwmem,
                     aluimm: bus.daluimm,
                     shift:  bus.dshift,
                     jal:    bus.djal};

  // Reset, stall and flush all leave the same all-zero bubble in E.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || w_stall || bus.flush) begin
      r_ectrl <= '0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_eimm  <= '0;
      r_epc4  <= '0;
      r_ealuc <= '0;
      r_ern   <= '0;
    end else begin
      r_ectrl <= w_dctrl;
      r_ea    <= bus.da;
      r_eb    <= bus.db;
      r_eimm  <= bus.dimm;
      r_epc4  <= bus.dpc4;
      r_ealuc <= bus.daluc;
      r_ern   <= w_drn;
    end
  end

  assign bus.wpcir   = !w_stall;
  assign bus.ea      = r_ea;
  assign bus.eb      = r_eb;
  assign bus.eimm    = r_eimm;
  assign bus.epc4    = r_epc4;
  assign bus.ealuc   = r_ealuc;
  assign bus.ern     = r_ern;
  assign bus.ewreg   = r_ectrl.wreg;
  assign bus.em2reg  = r_ectrl.m2reg;
  assign bus.ewmem   = r_ectrl.wmem;
  assign bus.ealuimm = r_ectrl.aluimm;
  assign bus.eshift  = r_ectrl.shift;
  assign bus.ejal    = r_ectrl.jal;

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Directed self-checking bench for idex_fwd_stage: reset, forwarding,
// priority, load-use stall, register 0, flush and jal destination.
module tb_idex_fwd_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  idex_fwd_stage_if bus();

  idex_fwd_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.use_rs = 1'b0; bus.use_rt = 1'b0;
    bus.da = '0; bus.db = '0; bus.dimm = '0; bus.dpc4 = '0;
    bus.dwreg = 1'b0; bus.dm2reg = 1'b0; bus.dwmem = 1'b0;
    bus.daluimm = 1'b0; bus.dshift = 1'b0; bus.djal = 1'b0; bus.dregrt = 1'b0;
    bus.daluc = '0; bus.flush = 1'b0;
    bus.mwreg = 1'b0; bus.mm2reg = 1'b0; bus.mrn = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.dwreg = 1'b1; bus.rd = 5'd7; bus.da = 32'hFFFF_FFFF;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_total++;
    if ({bus.ewreg, bus.em2reg, bus.ewmem, bus.ealuimm, bus.eshift, bus.ejal} !== 6'b0)
      $display("FAIL reset_ctrl got=%b want=000000",
               {bus.ewreg, bus.em2reg, bus.ewmem, bus.ealuimm, bus.eshift, bus.ejal});
    else n_pass++;
    n_total++;
    if ({bus.ea, bus.eb, bus.eimm, bus.epc4, bus.ealuc, bus.ern} !== '0)
      $display("FAIL reset_data ea=%h eb=%h eimm=%h epc4=%h ealuc=%h ern=%0d want all 0",
               bus.ea, bus.eb, bus.eimm, bus.epc4, bus.ealuc, bus.ern);
    else n_pass++;
    n_total++;
    if ({bus.wpcir, bus.fwda, bus.fwdb} !== 5'b1_00_00)
      $display("FAIL reset_hazard wpcir=%b fwda=%b fwdb=%b want 1/00/00",
               bus.wpcir, bus.fwda, bus.fwdb);
    else n_pass++;
  endtask

  task automatic test_fwd_exe();
    clear_inputs();
    bus.dwreg = 1'b1; bus.rd = 5'd8;
    bus.da = 32'h1111_0001; bus.db = 32'h2222_0002; bus.dimm = 32'h0000_ABCD;
    bus.daluc = 4'hA; bus.dshift = 1'b1;
    tick();
    clear_inputs();
    n_total++;
    if ({bus.ewreg, bus.ern, bus.ea, bus.eb, bus.eimm, bus.ealuc, bus.eshift} !==
        {1'b1, 5'd8, 32'h1111_0001, 32'h2222_0002, 32'h0000_ABCD, 4'hA, 1'b1})
      $display("FAIL capture ewreg=%b ern=%0d ea=%h eb=%h eimm=%h ealuc=%h eshift=%b",
               bus.ewreg, bus.ern, bus.ea, bus.eb, bus.eimm, bus.ealuc, bus.eshift);
    else n_pass++;
    bus.rs = 5'd8; bus.rt = 5'd3; bus.use_rs = 1'b1; bus.use_rt = 1'b1;
    #1;
    n_total++;
    if ({bus.fwda, bus.fwdb, bus.wpcir} !== 5'b01_00_1)
      $display("FAIL fwd_e_rs fwda=%b fwdb=%b wpcir=%b want 01/00/1",
               bus.fwda, bus.fwdb, bus.wpcir);
    else n_pass++;
    bus.rs = 5'd3; bus.rt = 5'd8;
    #1;
    n_total++;
    if ({bus.fwda, bus.fwdb} !== 4'b00_01)
      $display("FAIL fwd_e_rt fwda=%b fwdb=%b want 00/01", bus.fwda, bus.fwdb);
    else n_pass++;
  endtask

  task automatic test_priority();
    clear_inputs();
    bus.dwreg = 1'b1; bus.rd = 5'd8;
    tick();
    clear_inputs();
    bus.mwreg = 1'b1; bus.mm2reg = 1'b1; bus.mrn = 5'd8;
    bus.rs = 5'd8; bus.use_rs = 1'b1;
    #1;
    n_total++;
    if (bus.fwda !== 2'b01)
      $display("FAIL prio_e_over_m fwda=%b want 01", bus.fwda);
    else n_pass++;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    n_total++;
    if ({bus.ewreg, bus.fwda} !== 3'b0_11)
      $display("FAIL prio_m_load ewreg=%b fwda=%b want 0/11", bus.ewreg, bus.fwda);
    else n_pass++;
    bus.mm2reg = 1'b0;
    #1;
    n_total++;
    if (bus.fwda !== 2'b10)
      $display("FAIL fwd_m_alu fwda=%b want 10", bus.fwda);
    else n_pass++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.dwreg = 1'b1; bus.dm2reg = 1'b1; bus.dregrt = 1'b1; bus.rt = 5'd9;
    tick();
    clear_inputs();
    bus.dwreg = 1'b1; bus.rd = 5'd10; bus.rt = 5'd9; bus.use_rt = 1'b1;
    bus.da = 32'hDEAD_BEEF;
    #1;
    n_total++;
    if (bus.wpcir !== 1'b0)
      $display("FAIL load_use_stall wpcir=%b want 0", bus.wpcir);
    else n_pass++;
    tick();
    bus.mwreg = 1'b1; bus.mm2reg = 1'b1; bus.mrn = 5'd9;
    #1;
    n_total++;
    if ({bus.ewreg, bus.ern, bus.ea} !== {1'b0, 5'd0, 32'h0})
      $display("FAIL load_use_bubble ewreg=%b ern=%0d ea=%h want 0/0/0",
               bus.ewreg, bus.ern, bus.ea);
    else n_pass++;
    n_total++;
    if ({bus.fwdb, bus.wpcir} !== 3'b11_1)
      $display("FAIL load_use_after fwdb=%b wpcir=%b want 11/1", bus.fwdb, bus.wpcir);
    else n_pass++;
  endtask

  task automatic test_stall_flush_reset();
    clear_inputs();
    bus.dwreg = 1'b1; bus.dm2reg = 1'b1; bus.dregrt = 1'b1; bus.rt = 5'd12;
    tick();
    clear_inputs();
    bus.dwreg = 1'b1; bus.rd = 5'd4; bus.rs = 5'd12; bus.use_rs = 1'b1;
    bus.flush = 1'b1;
    #1;
    n_total++;
    if (bus.wpcir !== 1'b0)
      $display("FAIL stall_flush wpcir=%b want 0", bus.wpcir);
    else n_pass++;
    bus.flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_total++;
    if ({bus.ewreg, bus.ern, bus.wpcir} !== {1'b0, 5'd0, 1'b1})
      $display("FAIL reset_mid_stall ewreg=%b ern=%0d wpcir=%b want 0/0/1",
               bus.ewreg, bus.ern, bus.wpcir);
    else n_pass++;
  endtask

  task automatic test_reg0();
    clear_inputs();
    bus.dwreg = 1'b1; bus.dm2reg = 1'b1; bus.dregrt = 1'b1; bus.rt = 5'd0;
    tick();
    clear_inputs();
    bus.mwreg = 1'b1; bus.mrn = 5'd0;
    bus.rs = 5'd0; bus.rt = 5'd0; bus.use_rs = 1'b1; bus.use_rt = 1'b1;
    #1;
    n_total++;
    if ({bus.ewreg, bus.em2reg, bus.ern} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL reg0_setup ewreg=%b em2reg=%b ern=%0d want 1/1/0",
               bus.ewreg, bus.em2reg, bus.ern);
    else n_pass++;
    n_total++;
    if ({bus.fwda, bus.fwdb, bus.wpcir} !== 5'b00_00_1)
      $display("FAIL reg0_nofwd fwda=%b fwdb=%b wpcir=%b want 00/00/1",
               bus.fwda, bus.fwdb, bus.wpcir);
    else n_pass++;
  endtask

  task automatic test_flush_jal();
    clear_inputs();
    bus.dwreg = 1'b1; bus.rd = 5'd5; bus.da = 32'h5555_5555; bus.flush = 1'b1;
    tick();
    clear_inputs();
    n_total++;
    if ({bus.ewreg, bus.ern, bus.ea} !== {1'b0, 5'd0, 32'h0})
      $display("FAIL flush ewreg=%b ern=%0d ea=%h want 0/0/0",
               bus.ewreg, bus.ern, bus.ea);
    else n_pass++;
    bus.dwreg = 1'b1; bus.djal = 1'b1; bus.dregrt = 1'b1;
    bus.rd = 5'd6; bus.rt = 5'd7; bus.dpc4 = 32'h0040_1234;
    tick();
    clear_inputs();
    n_total++;
    if ({bus.ern, bus.epc4, bus.ejal, bus.ewreg} !== {5'd31, 32'h0040_1234, 1'b1, 1'b1})
      $display("FAIL jal ern=%0d epc4=%h ejal=%b ewreg=%b want 31/00401234/1/1",
               bus.ern, bus.epc4, bus.ejal, bus.ewreg);
    else n_pass++;
    bus.dwreg = 1'b1; bus.dregrt = 1'b1; bus.rd = 5'd6; bus.rt = 5'd7;
    tick();
    clear_inputs();
    n_total++;
    if (bus.ern !== 5'd7)
      $display("FAIL regrt ern=%0d want 7", bus.ern);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fwd_exe();
    test_priority();
    test_load_use();
    test_stall_flush_reset();
    test_reg0();
    test_flush_jal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
